// File: rtl/rocc_resp_gen_pkg.sv
// rocc_pkg: shared state and tag types for the RoCC response generator
package rocc_pkg;
  localparam int RD_WIDTH_DEFAULT = 5;
  typedef enum logic {IDLE, RESP} state_t;
  typedef struct packed {
    logic xd;
    logic [RD_WIDTH_DEFAULT-1:0] rd;
  } rocc_tag_t;
endpackage

// File: rtl/rocc_resp_gen_if.sv
// rocc_resp_gen_if: tag, result and response channels of the RoCC response generator
//   tag_*     : decoder pushes {xd, rd} per issued command, tag_ready = room left
//   op_*      : operation unit result strobe, output_module_BUSY = not accepted
//   resp_*    : valid/ready response {rd, data} to the core
//   busy, err_orphan : status
//   modport master drives the inputs, modport slave is the generator itself
interface rocc_resp_gen_if #(
  parameter int DATA_WIDTH   = 64,
  parameter int RESULT_WIDTH = 32,
  parameter int RD_WIDTH     = 5
);
  logic                    tag_valid;
  logic                    tag_xd;
  logic [RD_WIDTH-1:0]     tag_rd;
  logic                    tag_ready;
  logic [RESULT_WIDTH-1:0] op_result;
  logic                    op_output_STB;
  logic                    output_module_BUSY;
  logic                    resp_valid;
  logic                    resp_ready;
  logic [RD_WIDTH-1:0]     resp_rd;
  logic [DATA_WIDTH-1:0]   resp_data;
  logic                    busy;
  logic                    err_orphan;
  modport master (
    output tag_valid, tag_xd, tag_rd, op_result, op_output_STB, resp_ready,
    input  tag_ready, output_module_BUSY, resp_valid, resp_rd, resp_data, busy, err_orphan
  );
  modport slave (
    input  tag_valid, tag_xd, tag_rd, op_result, op_output_STB, resp_ready,
    output tag_ready, output_module_BUSY, resp_valid, resp_rd, resp_data, busy, err_orphan
  );
endinterface

// File: rtl/rocc_resp_gen_tag_fifo.sv
// rocc_tag_fifo: show-ahead tag FIFO with count-based full/empty, async active-high reset
//   clk, rst   : clock, asynchronous reset
//   push, din  : write (ignored while full)
//   pop, head  : read (ignored while empty), head shows the oldest entry
//   count, full, empty : occupancy
module rocc_tag_fifo #(
  parameter int W     = 6,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic          do_push, do_pop;
  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rp];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      wp    <= do_push ? wp + 1'b1 : wp;
      rp    <= do_pop ? rp + 1'b1 : rp;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
endmodule

// File: rtl/rocc_resp_gen.sv
// rocc_resp_gen: pairs operation-unit results with queued rd tags and returns RoCC responses
//   clk, rst : clock, asynchronous active-high reset
//   bus      : rocc_resp_gen_if.slave (tag push, result strobe, response, status)
//   ROCC_RESP_SIGN_EXT_EN defined: resp_data sign-extends op_result, otherwise zero-extends
module rocc_resp_gen
  import rocc_pkg::*;
#(
  parameter int DATA_WIDTH   = 64,
  parameter int RESULT_WIDTH = 32,
  parameter int RD_WIDTH     = RD_WIDTH_DEFAULT,
  parameter int TAG_DEPTH    = 4
) (
  input  logic           clk,
  input  logic           rst,
  rocc_resp_gen_if.slave bus
);
  state_t                     state, state_n;
  logic [RD_WIDTH:0]          head;
  logic [$clog2(TAG_DEPTH):0] count;
  logic                       full, empty, acc, pop, load, err;
  logic [RD_WIDTH-1:0]        rd_q;
  logic [DATA_WIDTH-1:0]      data_q, ext;
  rocc_tag_fifo #(.W(RD_WIDTH + 1), .DEPTH(TAG_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.tag_valid),
    .din   ({bus.tag_xd, bus.tag_rd}),
    .pop   (pop),
    .head  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );
`ifdef ROCC_RESP_SIGN_EXT_EN
  assign ext = {{(DATA_WIDTH-RESULT_WIDTH){bus.op_result[RESULT_WIDTH-1]}}, bus.op_result};
`else
  assign ext = {{(DATA_WIDTH-RESULT_WIDTH){1'b0}}, bus.op_result};
`endif
  // a tag pushed in the same cycle is not yet visible, so the result is an orphan
  assign acc  = bus.op_output_STB && state == IDLE;
  assign pop  = acc && !empty;
  assign load = pop && head[RD_WIDTH];
  assign bus.tag_ready          = !full;
  assign bus.output_module_BUSY = state == RESP;
  assign bus.resp_valid         = state == RESP;
  assign bus.resp_rd            = rd_q;
  assign bus.resp_data          = data_q;
  assign bus.busy               = count != '0 || state == RESP;
  assign bus.err_orphan         = err;
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (load ? RESP : IDLE) : (bus.resp_ready ? IDLE : RESP);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_n;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rd_q   <= '0;
      data_q <= '0;
      err    <= 1'b0;
    end else begin
      rd_q   <= load ? head[RD_WIDTH-1:0] : rd_q;
      data_q <= load ? ext : data_q;
      err    <= err || (acc && empty);
    end
endmodule

// File: tb/tb_rocc_resp_gen.sv
// tb_rocc_resp_gen: scoreboard bench for rocc_resp_gen with directed vectors
module tb_rocc_resp_gen;
`ifdef ROCC_RESP_SIGN_EXT_EN
  localparam logic [63:0] EXT8 = 64'hFFFF_FFFF_8000_0001;
  localparam logic [63:0] EXTF = 64'hFFFF_FFFF_FFFF_FFFF;
`else
  localparam logic [63:0] EXT8 = 64'h0000_0000_8000_0001;
  localparam logic [63:0] EXTF = 64'h0000_0000_FFFF_FFFF;
`endif
  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  logic [68:0] q[$];
  logic [68:0] exp_v;
  always #5 clk = ~clk;
  rocc_resp_gen_if bus ();
  rocc_resp_gen dut (.clk(clk), .rst(rst), .bus(bus));
  task automatic chk(string n, logic [63:0] a, logic [63:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic push(logic xd, logic [4:0] rd);
    bus.tag_valid = 1'b1;
    bus.tag_xd    = xd;
    bus.tag_rd    = rd;
    step();
    bus.tag_valid = 1'b0;
  endtask
  task automatic strobe(logic [31:0] r);
    bus.op_result     = r;
    bus.op_output_STB = 1'b1;
    step();
    bus.op_output_STB = 1'b0;
  endtask
  always @(negedge clk)
    if (!rst && bus.resp_valid && bus.resp_ready) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_resp: got rd=%0d data=%h want none", bus.resp_rd, bus.resp_data);
      end else begin
        exp_v = q.pop_front();
        chk("resp_rd", 64'(bus.resp_rd), 64'(exp_v[68:64]));
        chk("resp_data", bus.resp_data, exp_v[63:0]);
      end
    end
  initial begin
    rst = 1'b1;
    bus.tag_valid = 1'b0;
    bus.tag_xd = 1'b0;
    bus.tag_rd = '0;
    bus.op_result = '0;
    bus.op_output_STB = 1'b0;
    bus.resp_ready = 1'b0;
    #12;
    chk("rst_resp_valid", 64'(bus.resp_valid), 0);
    chk("rst_tag_ready", 64'(bus.tag_ready), 1);
    chk("rst_busy", 64'(bus.busy), 0);
    chk("rst_out_busy", 64'(bus.output_module_BUSY), 0);
    chk("rst_err", 64'(bus.err_orphan), 0);
    @(negedge clk) rst = 1'b0;
    step();
    push(1'b1, 5'd5);
    q.push_back({5'd5, 64'h1234});
    strobe(32'h0000_1234);
    chk("t1_valid", 64'(bus.resp_valid), 1);
    chk("t1_out_busy", 64'(bus.output_module_BUSY), 1);
    chk("t1_rd", 64'(bus.resp_rd), 5);
    chk("t1_data", bus.resp_data, 64'h1234);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t1_hold_valid", 64'(bus.resp_valid), 1);
      chk("t1_hold_data", bus.resp_data, 64'h1234);
      chk("t1_hold_out_busy", 64'(bus.output_module_BUSY), 1);
    end
    bus.resp_ready = 1'b1;
    step();
    chk("t1_done_valid", 64'(bus.resp_valid), 0);
    chk("t1_done_out_busy", 64'(bus.output_module_BUSY), 0);
    push(1'b0, 5'd3);
    chk("t2_busy_before", 64'(bus.busy), 1);
    strobe(32'hDEAD_BEEF);
    chk("t2_busy_after", 64'(bus.busy), 0);
    chk("t2_valid", 64'(bus.resp_valid), 0);
    for (int i = 1; i <= 4; i++) push(1'b1, 5'(i));
    chk("t3_full", 64'(bus.tag_ready), 0);
    push(1'b1, 5'd9);
    for (int i = 1; i <= 4; i++) begin
      q.push_back({5'(i), 64'h100 + 64'(i)});
      strobe(32'h100 + 32'(i));
      step();
    end
    chk("t3_tag_ready", 64'(bus.tag_ready), 1);
    chk("t3_busy", 64'(bus.busy), 0);
    push(1'b1, 5'd7);
    q.push_back({5'd7, EXT8});
    strobe(32'h8000_0001);
    step();
    chk("t5_err_before", 64'(bus.err_orphan), 0);
    strobe(32'h77);
    chk("t5_err", 64'(bus.err_orphan), 1);
    chk("t5_valid", 64'(bus.resp_valid), 0);
    for (int i = 0; i < 3; i++) step();
    chk("t5_err_sticky", 64'(bus.err_orphan), 1);
    bus.tag_valid = 1'b1;
    bus.tag_xd = 1'b1;
    bus.tag_rd = 5'd6;
    bus.op_result = 32'h66;
    bus.op_output_STB = 1'b1;
    step();
    bus.tag_valid = 1'b0;
    bus.op_output_STB = 1'b0;
    chk("t5_same_cycle_busy", 64'(bus.busy), 1);
    chk("t5_same_cycle_valid", 64'(bus.resp_valid), 0);
    bus.resp_ready = 1'b0;
    strobe(32'h55);
    chk("t6_valid", 64'(bus.resp_valid), 1);
    chk("t6_rd", 64'(bus.resp_rd), 6);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_valid", 64'(bus.resp_valid), 0);
    chk("t6_rst_tag_ready", 64'(bus.tag_ready), 1);
    chk("t6_rst_busy", 64'(bus.busy), 0);
    chk("t6_rst_err", 64'(bus.err_orphan), 0);
    chk("t6_rst_out_busy", 64'(bus.output_module_BUSY), 0);
    @(negedge clk) rst = 1'b0;
    bus.resp_ready = 1'b1;
    step();
    push(1'b1, 5'd31);
    q.push_back({5'd31, EXTF});
    strobe(32'hFFFF_FFFF);
    for (int i = 0; i < 20 && q.size() != 0; i++) step();
    chk("drain", 64'(q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
